// File: rtl/sram_like_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_slave_pkg
// Description : Shared types and constants for the sram-like responder.
//               Holds the size codes, the stall LFSR seed and its step
//               function, and the response FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_like_slave_pkg;

    // Transfer size codes carried on the size bus. They are informational
    // only, because wstrb alone decides which bytes a write touches.
    localparam logic [1:0]  c_size_byte = 2'd0;
    localparam logic [1:0]  c_size_half = 2'd1;
    localparam logic [1:0]  c_size_word = 2'd2;

    // Seed loaded into the stall LFSR on reset.
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;

    // One response FIFO entry. Write responses carry zero data.
    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } resp_t;

    // Right-shifting Fibonacci LFSR with taps 16,14,13,11. Those taps
    // correspond to state bits 0, 2, 3 and 5.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_slave_if
// Description : sram-like req/addr_ok/data_ok bus.
//               The master drives req, wr, size, wstrb, addr and wdata.
//               The slave returns addr_ok, data_ok and rdata.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_like_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_resp_fifo
// Description : In-order response FIFO. It is DEPTH entries deep and
//               WIDTH bits wide. A push and a pop may occur in the same
//               cycle. The caller must never push when the FIFO is full
//               or pop when it is empty; the responder's outstanding
//               counter guarantees both.
// Ports       : clk, reset (sync, active-high)
//               i_push / i_push_data - write an entry at the tail
//               i_pop                - drop the head entry
//               o_empty / o_head     - status and current head entry
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic                  o_empty,
    output logic [WIDTH-1:0]      o_head
);
    localparam int                 c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // The storage array has no reset, because the pointers alone define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/sram_like_slave.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_slave
// Description : Responder for the sram-like req/addr_ok/data_ok protocol.
//               It holds a word-addressed 32-bit RAM behind an in-order,
//               multi-outstanding response path.
//
//               When there is no stall, a request accepted in cycle T
//               completes with data_ok in cycle T+READ_LAT.
//
//               Optional macro SRAM_SLAVE_RAND_STALL_EN enables LFSR-driven
//               pseudo-random gating of addr_ok and of FIFO head release.
// Ports       : clk, reset (sync, active-high)
//               bus (slave modport): req, wr, size, wstrb, addr, wdata in;
//                                    addr_ok, data_ok, rdata out
// Parameters  : MEM_AW   - word-address width (2**MEM_AW words)
//               READ_LAT - accept-to-data_ok latency, 1..8
//               MAX_OUTS - max accepted-but-unanswered requests, 1..8
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_slave
    import sram_like_slave_pkg::*;
#(
    parameter int MEM_AW   = 12,
    parameter int READ_LAT = 2,
    parameter int MAX_OUTS = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sram_like_slave_if.slave  bus
);
    localparam int                 c_cnt_w    = $clog2(MAX_OUTS + 1);
    localparam int                 c_pipe_n   = READ_LAT - 1;
    localparam logic [c_cnt_w-1:0] c_max_outs = c_cnt_w'(MAX_OUTS);

    logic [31:0]        r_mem [2**MEM_AW];
    logic [c_cnt_w-1:0] r_outs_cnt;
    logic [MEM_AW-1:0]  w_widx;
    logic               w_accept;
    logic               w_addr_gate;
    logic               w_pop_gate;
    logic               w_push;
    logic               w_fifo_empty;
    resp_t              w_acc_entry;
    resp_t              w_push_entry;
    resp_t              w_head;

    // Upper address bits alias onto the RAM. The byte offset and size are
    // informational only.
    wire logic w_unused = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

    assign w_widx   = bus.addr[MEM_AW+1:2];
    assign w_accept = bus.req && bus.addr_ok;

`ifdef SRAM_SLAVE_RAND_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= c_lfsr_seed;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_addr_gate = r_lfsr[0];
    assign w_pop_gate  = r_lfsr[1];
`else
    assign w_addr_gate = 1'b1;
    assign w_pop_gate  = 1'b1;
`endif

    // A full slot count blocks acceptance even in a cycle that retires a
    // response. A freed credit only becomes usable in the next cycle.
    assign bus.addr_ok = !reset && (r_outs_cnt < c_max_outs) && w_addr_gate;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outs_cnt <= '0;
        end else if (w_accept && !bus.data_ok) begin
            r_outs_cnt <= r_outs_cnt + 1'b1;
        end else if (!w_accept && bus.data_ok) begin
            r_outs_cnt <= r_outs_cnt - 1'b1;
        end
    end

    // Writes land at the accept edge. A read accepted in any later cycle
    // therefore observes them. RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    r_mem[w_widx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    // The read happens in the accept cycle. Its result then travels
    // through READ_LAT-1 register stages before entering the FIFO.
    always_comb begin
        w_acc_entry       = '0;
        w_acc_entry.is_rd = !bus.wr;
        w_acc_entry.data  = bus.wr ? 32'h0 : r_mem[w_widx];
    end

    generate
        if (c_pipe_n == 0) begin : g_no_pipe
            assign w_push       = w_accept;
            assign w_push_entry = w_acc_entry;
        end else begin : g_pipe
            logic  r_vld [c_pipe_n];
            resp_t r_ent [c_pipe_n];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < c_pipe_n; i++) begin
                        r_vld[i] <= 1'b0;
                    end
                end else begin
                    r_vld[0] <= w_accept;
                    for (int i = 1; i < c_pipe_n; i++) begin
                        r_vld[i] <= r_vld[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_ent[0] <= w_acc_entry;
                for (int i = 1; i < c_pipe_n; i++) begin
                    r_ent[i] <= r_ent[i-1];
                end
            end

            assign w_push       = r_vld[c_pipe_n-1];
            assign w_push_entry = r_ent[c_pipe_n-1];
        end
    endgenerate

    // The FIFO cannot overflow: pipe plus FIFO occupancy never exceeds
    // r_outs_cnt, which never exceeds MAX_OUTS.
    sram_like_resp_fifo #(
        .DEPTH (MAX_OUTS),
        .WIDTH ($bits(resp_t))
    ) u_resp_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (bus.data_ok),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head)
    );

    // The head entry is released as soon as it exists, because data_ok
    // has no backpressure. During reset, data_ok is forced low so that no
    // stale response escapes.
    assign bus.data_ok = !reset && !w_fifo_empty && w_pop_gate;
    assign bus.rdata   = (bus.data_ok && w_head.is_rd) ? w_head.data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_slave
// Description : Self-checking bench for sram_like_slave.
//               dut_a uses READ_LAT=2 and MAX_OUTS=4. It takes the
//               directed write/read case and a 1000-operation random run,
//               scored against a byte-level memory model and an
//               accept-order queue.
//               dut_b uses READ_LAT=8 and MAX_OUTS=4. It takes the
//               partial-write, full-credit and reset-drop cases.
//               Honours SRAM_SLAVE_RAND_STALL_EN by relaxing exact
//               latency to a lower bound.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_slave;
    import sram_like_slave_pkg::*;

    localparam int AW    = 12;
    localparam int LAT_A = 2;
    localparam int LAT_B = 8;
    localparam int OUTS  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_slave_if bus_a ();
    sram_like_slave_if bus_b ();

    sram_like_slave #(.MEM_AW(AW), .READ_LAT(LAT_A), .MAX_OUTS(OUTS)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sram_like_slave #(.MEM_AW(AW), .READ_LAT(LAT_B), .MAX_OUTS(OUTS)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model for dut_a ----------------
    typedef struct {
        logic [31:0] data;
        bit          known;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem   [2**AW];
    logic [3:0]  m_known [2**AW];

    always @(negedge clk) begin
        exp_t          e;
        bit            allowed;
        bit            due;
        logic [AW-1:0] idx;
        if (reset) begin
            exp_q.delete();
        end else begin
            allowed = (exp_q.size() > 0) && ((cyc - exp_q[0].acc) >= LAT_A);
            due     = (exp_q.size() > 0) && ((cyc - exp_q[0].acc) == LAT_A);
`ifdef SRAM_SLAVE_RAND_STALL_EN
            if (bus_a.data_ok) chk("a_data_ok_too_early", 32'(allowed), 32'd1);
`else
            chk("a_data_ok_timing", 32'(bus_a.data_ok), 32'(due));
`endif
            if (bus_a.data_ok && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.known) chk("a_rdata", bus_a.rdata, e.data);
            end else if (!bus_a.data_ok) begin
                chk("a_rdata_idle", bus_a.rdata, 32'h0);
`ifndef SRAM_SLAVE_RAND_STALL_EN
                if (due) void'(exp_q.pop_front());
`endif
            end
            if (bus_a.req && bus_a.addr_ok) begin
                idx = bus_a.addr[AW+1:2];
                if (bus_a.wr) begin
                    for (int i = 0; i < 4; i++)
                        if (bus_a.wstrb[i]) m_mem[idx][8*i +: 8] = bus_a.wdata[8*i +: 8];
                    m_known[idx] = m_known[idx] | bus_a.wstrb;
                    e.data = 32'h0; e.known = 1'b1;
                end else begin
                    e.data = m_mem[idx]; e.known = (m_known[idx] == 4'hF);
                end
                e.acc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue_a(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        bus_a.req = 1'b1; bus_a.wr = w; bus_a.addr = a;
        bus_a.wstrb = s; bus_a.wdata = d; bus_a.size = c_size_word;
        @(negedge clk);
        while (!bus_a.addr_ok && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("a_accept_timeout", 32'(bus_a.addr_ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic issue_b(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        bus_b.req = 1'b1; bus_b.wr = w; bus_b.addr = a;
        bus_b.wstrb = s; bus_b.wdata = d; bus_b.size = c_size_word;
        @(negedge clk);
        while (!bus_b.addr_ok && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("b_accept_timeout", 32'(bus_b.addr_ok), 32'd1);
        acc_b = cyc;
        @(posedge clk); #1;
        bus_b.req = 1'b0;
    endtask

    task automatic resp_b(input string tag, input logic [31:0] exp_d);
        int n = 0;
        @(negedge clk);
        while (!bus_b.data_ok && n < 200) begin @(negedge clk); n++; end
        chk({tag, "_data_ok"}, 32'(bus_b.data_ok), 32'd1);
        chk({tag, "_rdata"}, bus_b.rdata, exp_d);
`ifdef SRAM_SLAVE_RAND_STALL_EN
        chk({tag, "_lat_min"}, 32'((cyc - acc_b) >= LAT_B), 32'd1);
`else
        chk({tag, "_lat"}, 32'(cyc - acc_b), 32'(LAT_B));
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int cnt;
        logic [31:0] a;
        for (int i = 0; i < 2**AW; i++) m_known[i] = 4'h0;
        bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.size = 2'd0; bus_a.wstrb = 4'h0;
        bus_a.addr = 32'h0; bus_a.wdata = 32'h0;
        bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = 2'd0; bus_b.wstrb = 4'h0;
        bus_b.addr = 32'h0; bus_b.wdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_addr_ok", 32'(bus_a.addr_ok), 32'd0);
        chk("rst_a_data_ok", 32'(bus_a.data_ok), 32'd0);
        chk("rst_a_rdata",   bus_a.rdata,        32'h0);
        chk("rst_b_addr_ok", 32'(bus_b.addr_ok), 32'd0);
        chk("rst_b_data_ok", 32'(bus_b.data_ok), 32'd0);
        chk("rst_b_rdata",   bus_b.rdata,        32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
`ifndef SRAM_SLAVE_RAND_STALL_EN
        chk("post_rst_a_addr_ok", 32'(bus_a.addr_ok), 32'd1);
        chk("post_rst_b_addr_ok", 32'(bus_b.addr_ok), 32'd1);
`endif
        @(posedge clk); #1;

        // Write then read-back on consecutive cycles (scored by the model)
        issue_a(1'b1, 32'h1C00_0000, 4'hF, 32'hDEAD_BEEF);
        issue_a(1'b0, 32'h1C00_0000, 4'hF, 32'h0);
        bus_a.req = 1'b0;
        repeat (6) @(posedge clk); #1;

        // Random run against the model. Seed 16 words first so every read
        // has a known expectation. Random upper bits exercise aliasing.
        for (int i = 0; i < 16; i++) begin
            a = ($urandom() & 32'hFFFF_C000) | (32'(i) << 2) | 32'($urandom_range(0, 3));
            issue_a(1'b1, a, 4'hF, $urandom());
        end
        for (int k = 0; k < 1000; k++) begin
            a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2);
            issue_a(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom());
            if ($urandom_range(0, 3) == 0) begin
                bus_a.req = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        bus_a.req = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin @(negedge clk); n++; end
        chk("a_drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Partial write merges into the existing word
        issue_b(1'b1, 32'h0000_0040, 4'hF, 32'h1122_3344);
        resp_b("b_wr_full", 32'h0);
        issue_b(1'b1, 32'hF000_0040, 4'b0010, 32'h0000_AB00);
        resp_b("b_wr_part", 32'h0);
        issue_b(1'b0, 32'h0000_0040, 4'h0, 32'h0);
        resp_b("b_rd_merge", 32'h1122_AB44);

`ifndef SRAM_SLAVE_RAND_STALL_EN
        // Full credit: four accepts, blocked until the cycle after the
        // first data_ok
        bus_b.req = 1'b1; bus_b.wr = 1'b0; bus_b.addr = 32'h0000_0080;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("b_full_addr_ok_c%0d", k), 32'(bus_b.addr_ok), 32'(k < 4 || k == 9));
            chk($sformatf("b_full_data_ok_c%0d", k), 32'(bus_b.data_ok), 32'(k >= 8));
        end
        @(posedge clk); #1;
        bus_b.req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_b.data_ok) cnt++;
        end
        chk("b_full_tail_responses", 32'(cnt), 32'd3);
        @(posedge clk); #1;
`endif

        // Reset one cycle after three accepted reads: none may answer
        issue_b(1'b0, 32'h0000_0040, 4'h0, 32'h0);
        issue_b(1'b0, 32'h0000_0040, 4'h0, 32'h0);
        issue_b(1'b0, 32'h0000_0040, 4'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("b_rst_data_ok_during", 32'(bus_b.data_ok), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus_b.data_ok) cnt++;
        end
        chk("b_rst_dropped_responses", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        issue_b(1'b0, 32'h0000_0040, 4'h0, 32'h0);
        resp_b("b_rd_after_rst", 32'h1122_AB44);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
